memwrite_checker: RTL and testbench

Synthesizable self-check monitor for the multi-cycle MIPS CPU's data-memory write bus. It replaces the single hard-coded "7 to address 84" bench check with a programmable table of up to NUM_EXP expected (address, data) writes, an optional tolerated scratch address, an ordered/unordered match mode and a cycle timeout. It sits beside `top`, snooping `memwrite`/`dataadr`/`writedata`, and drives registered pass/fail status for benches or an FPGA LED.

---
 rtl/memwrite_checker_pkg.sv | 23 ++
 rtl/memwrite_checker_if.sv | 12 +
 rtl/memwrite_checker_table.sv | 75 +++++++
 rtl/memwrite_checker.sv | 136 +++++++++++++
 tb/tb_memwrite_checker.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/memwrite_checker_pkg.sv
// Shared types for the data-memory write checker: FSM states, failure codes
// and a width helper for table indices.
package memchk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_UNEXP   = 2'd1,
        FC_TIMEOUT = 2'd2
    } fc_t;

    // A one-entry table still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memwrite_checker_if.sv
// Snooped CPU data-memory write bus. The CPU side drives it, the checker listens.
interface memwrite_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              memwrite;
    logic [ADDR_W-1:0] dataadr;
    logic [DATA_W-1:0] writedata;

    modport master (output memwrite, output dataadr, output writedata);
    modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/memwrite_checker_table.sv
// Expected-write table: entry storage, per-entry matched flags and the
// lowest-index candidate select for both ordered and unordered matching.
module memchk_table
    import memchk_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int ORDERED = 1,
    parameter int IDX_W   = 2,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [ADDR_W-1:0] prog_adr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              clr,
    input  logic              take,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  num_act,
    input  logic [CNT_W-1:0]  match_count,
    output logic              hit,
    output logic [IDX_W-1:0]  hit_idx
);

    logic [NUM_EXP-1:0][ADDR_W-1:0] ent_adr;
    logic [NUM_EXP-1:0][DATA_W-1:0] ent_data;
    logic [NUM_EXP-1:0]             matched;
    logic [NUM_EXP-1:0]             cand;

    // Table contents have no reset; they are only meaningful once programmed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EXP; i++) begin
            if (prog_we && prog_idx == IDX_W'(i)) begin
                ent_adr[i]  <= prog_adr;
                ent_data[i] <= prog_data;
            end
        end
    end

    // Matched flags: cleared on reset and at every run start, set on a taken hit.
    always_ff @(posedge clk) begin
        if (reset || clr)
            matched <= '0;
        else if (take && hit)
            matched[hit_idx] <= 1'b1;
    end

    // Candidate entries: full-width equality, active, and either the next
    // in-order entry or a not-yet-matched entry depending on the mode.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            cand[i] = (ent_adr[i] == adr) && (ent_data[i] == data) &&
                      (CNT_W'(i) < num_act) &&
                      ((ORDERED != 0) ? (CNT_W'(i) == match_count) : !matched[i]);
        end
    end

    // Lowest index wins so duplicate table entries are consumed in order.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_EXP - 1; i >= 0; i--) begin
            if (cand[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/memwrite_checker.sv
// Self-check monitor for the CPU data-memory write bus: runs a programmed
// table of expected writes against the snooped bus and reports pass/fail.
module memwrite_checker
    import memchk_pkg::*;
#(
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int NUM_EXP = 4,
    parameter  int ORDERED = 1,
    parameter  int TIMEOUT = 4096,
    localparam int IDX_W   = idx_width(NUM_EXP),
    localparam int CNT_W   = $clog2(NUM_EXP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [ADDR_W-1:0] prog_adr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [CNT_W-1:0]  num_exp,
    input  logic              ignore_en,
    input  logic [ADDR_W-1:0] ignore_adr,
    input  logic              start,
    memwrite_checker_if.slave bus,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data,
    output logic [CNT_W-1:0]  match_count
);

    localparam int TMR_W = $clog2(TIMEOUT);

    state_t             state;
    fc_t                fc;
    logic [CNT_W-1:0]   num_lat;
    logic [CNT_W-1:0]   mc_nxt;
    logic [TMR_W-1:0]   timer;
    logic               running;
    logic               begin_run;
    logic               take;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               ign_hit;
    logic               tmo;

    assign running   = (state == RUN);
    assign begin_run = start && !running;
    assign take      = running && bus.memwrite && (num_lat != '0);
    assign ign_hit   = ignore_en && (bus.dataadr == ignore_adr);
    assign tmo       = (timer == TMR_W'(TIMEOUT - 1));
    assign mc_nxt    = match_count + CNT_W'(1);

    memchk_table #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_EXP (NUM_EXP),
        .ORDERED (ORDERED),
        .IDX_W   (IDX_W),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .prog_we     (prog_we && !running),
        .prog_idx    (prog_idx),
        .prog_adr    (prog_adr),
        .prog_data   (prog_data),
        .clr         (begin_run),
        .take        (take),
        .adr         (bus.dataadr),
        .data        (bus.writedata),
        .num_act     (num_lat),
        .match_count (match_count),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    // Run FSM, timer and failure capture. A completing match beats a timeout
    // landing on the same cycle; an ignored or partial write on the last
    // cycle still times out so the timer never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            fc          <= FC_NONE;
            fail_adr    <= '0;
            fail_data   <= '0;
            match_count <= '0;
            num_lat     <= '0;
            timer       <= '0;
        end else begin
            case (state)
                RUN: begin
                    timer <= timer + TMR_W'(1);
                    if (num_lat == '0) begin
                        state <= PASS;
                    end else if (bus.memwrite && hit) begin
                        match_count <= mc_nxt;
                        if (mc_nxt == num_lat) begin
                            state <= PASS;
                        end else if (tmo) begin
                            state <= FAIL;
                            fc    <= FC_TIMEOUT;
                        end
                    end else if (bus.memwrite && !ign_hit) begin
                        state     <= FAIL;
                        fc        <= FC_UNEXP;
                        fail_adr  <= bus.dataadr;
                        fail_data <= bus.writedata;
                    end else if (tmo) begin
                        state <= FAIL;
                        fc    <= FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        state       <= RUN;
                        fc          <= FC_NONE;
                        fail_adr    <= '0;
                        fail_data   <= '0;
                        match_count <= '0;
                        num_lat     <= num_exp;
                        timer       <= '0;
                    end
                end
            endcase
        end
    end

    assign pass      = (state == PASS);
    assign fail      = (state == FAIL);
    assign done      = pass | fail;
    assign fail_code = fc;

endmodule

// File: tb/tb_memwrite_checker.sv
// Directed bench: an ordered and an unordered checker share one stimulus
// stream, both with a short timeout so timeout behaviour is quick to reach.
module tb_memwrite_checker;
    import memchk_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        prog_we;
    logic [1:0]  prog_idx;
    logic [31:0] prog_adr, prog_data;
    logic [2:0]  num_exp;
    logic        ignore_en;
    logic [31:0] ignore_adr;
    logic        start;

    logic        o_done, o_pass, o_fail, u_done, u_pass, u_fail;
    logic [1:0]  o_fc, u_fc;
    logic [31:0] o_fa, o_fd, u_fa, u_fd;
    logic [2:0]  o_mc, u_mc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memwrite_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    memwrite_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_EXP(4), .ORDERED(1), .TIMEOUT(16)) u_ord (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_adr(prog_adr), .prog_data(prog_data), .num_exp(num_exp),
        .ignore_en(ignore_en), .ignore_adr(ignore_adr), .start(start), .bus(bus),
        .done(o_done), .pass(o_pass), .fail(o_fail), .fail_code(o_fc),
        .fail_adr(o_fa), .fail_data(o_fd), .match_count(o_mc)
    );

    memwrite_checker #(.ADDR_W(AW), .DATA_W(DW), .NUM_EXP(4), .ORDERED(0), .TIMEOUT(16)) u_uno (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_adr(prog_adr), .prog_data(prog_data), .num_exp(num_exp),
        .ignore_en(ignore_en), .ignore_adr(ignore_adr), .start(start), .bus(bus),
        .done(u_done), .pass(u_pass), .fail(u_fail), .fail_code(u_fc),
        .fail_adr(u_fa), .fail_data(u_fd), .match_count(u_mc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Status of one DUT: done, pass, fail, code, adr, data, count
    task automatic chk_ord(input string tag, input logic d, input logic p, input logic f,
                           input logic [1:0] c, input logic [31:0] a, input logic [31:0] dt,
                           input logic [2:0] m);
        chk({tag, ".o.done"}, 32'(o_done), 32'(d));
        chk({tag, ".o.pass"}, 32'(o_pass), 32'(p));
        chk({tag, ".o.fail"}, 32'(o_fail), 32'(f));
        chk({tag, ".o.code"}, 32'(o_fc), 32'(c));
        chk({tag, ".o.adr"},  o_fa, a);
        chk({tag, ".o.data"}, o_fd, dt);
        chk({tag, ".o.mc"},   32'(o_mc), 32'(m));
    endtask

    task automatic chk_uno(input string tag, input logic d, input logic p, input logic f,
                           input logic [1:0] c, input logic [31:0] a, input logic [31:0] dt,
                           input logic [2:0] m);
        chk({tag, ".u.done"}, 32'(u_done), 32'(d));
        chk({tag, ".u.pass"}, 32'(u_pass), 32'(p));
        chk({tag, ".u.fail"}, 32'(u_fail), 32'(f));
        chk({tag, ".u.code"}, 32'(u_fc), 32'(c));
        chk({tag, ".u.adr"},  u_fa, a);
        chk({tag, ".u.data"}, u_fd, dt);
        chk({tag, ".u.mc"},   32'(u_mc), 32'(m));
    endtask

    task automatic prog(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_idx = idx; prog_adr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
        tick();
        bus.memwrite = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_adr = '0; prog_data = '0;
        num_exp = '0; ignore_en = 1'b0; ignore_adr = '0; start = 1'b0;
        bus.memwrite = 1'b0; bus.dataadr = '0; bus.writedata = '0;
        tick(); tick();
        chk_ord("reset", 0, 0, 0, 0, 0, 0, 0);
        chk_uno("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Single expected write with a tolerated scratch write first
        prog(0, 84, 7);
        num_exp = 1; ignore_en = 1'b1; ignore_adr = 80;
        go();
        chk_ord("run0", 0, 0, 0, 0, 0, 0, 0);
        wr(80, 5);
        chk_ord("ignored", 0, 0, 0, 0, 0, 0, 0);
        wr(84, 7);
        chk_ord("pass84", 1, 1, 0, 0, 0, 0, 1);
        chk_uno("pass84", 1, 1, 0, 0, 0, 0, 1);

        // Wrong address
        go();
        chk_ord("restart", 0, 0, 0, 0, 0, 0, 0);
        wr(88, 7);
        chk_ord("unexp88", 1, 0, 1, 1, 88, 7, 0);
        chk_uno("unexp88", 1, 0, 1, 1, 88, 7, 0);
        wr(84, 7);
        chk_ord("hold_fail", 1, 0, 1, 1, 88, 7, 0);

        // Two entries written out of order
        prog(0, 4, 1);
        prog(1, 8, 2);
        num_exp = 2;
        go();
        wr(8, 2);
        chk_ord("ooo1", 1, 0, 1, 1, 8, 2, 0);
        chk_uno("ooo1", 0, 0, 0, 0, 0, 0, 1);
        wr(4, 1);
        chk_ord("ooo2", 1, 0, 1, 1, 8, 2, 0);
        chk_uno("ooo2", 1, 1, 0, 0, 0, 0, 2);

        // Duplicate write of an already-matched entry
        go();
        wr(4, 1);
        chk_uno("dup1", 0, 0, 0, 0, 0, 0, 1);
        wr(4, 1);
        chk_ord("dup2", 1, 0, 1, 1, 4, 1, 1);
        chk_uno("dup2", 1, 0, 1, 1, 4, 1, 1);

        // In-order back-to-back writes
        go();
        wr(4, 1);
        wr(8, 2);
        chk_ord("inord", 1, 1, 0, 0, 0, 0, 2);
        chk_uno("inord", 1, 1, 0, 0, 0, 0, 2);

        // Timeout: fail lands 16 cycles after RUN entry
        go();
        for (int i = 0; i < 15; i++) tick();
        chk_ord("tmo15", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_ord("tmo16", 1, 0, 1, 2, 0, 0, 0);
        chk_uno("tmo16", 1, 0, 1, 2, 0, 0, 0);

        // Completing match on the final cycle wins over timeout
        num_exp = 1;
        go();
        for (int i = 0; i < 15; i++) tick();
        wr(4, 1);
        chk_ord("lastmatch", 1, 1, 0, 0, 0, 0, 1);
        chk_uno("lastmatch", 1, 1, 0, 0, 0, 0, 1);

        // Empty table passes right after the first RUN cycle
        num_exp = 0;
        go();
        chk_ord("empty0", 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_ord("empty1", 1, 1, 0, 0, 0, 0, 0);

        // Reset in the middle of a run, then a clean restart; programming
        // attempted during the run must not disturb the table
        num_exp = 2;
        go();
        wr(4, 1);
        chk_ord("mid", 0, 0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        tick();
        chk_ord("midrst", 0, 0, 0, 0, 0, 0, 0);
        chk_uno("midrst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        go();
        prog(1, 12, 3);
        wr(4, 1);
        wr(8, 2);
        chk_ord("restart_pass", 1, 1, 0, 0, 0, 0, 2);
        chk_uno("restart_pass", 1, 1, 0, 0, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
